// File: rtl/json_rx_pkg.sv
// Shared types and constants for the JSON feedback-frame decoder.
package json_rx_pkg;

    // Parser states; see the state table in json_rx_decoder.
    typedef enum logic [3:0] {
        IDLE,
        KEY_OPEN,
        KEY_CHAR,
        KEY_CLOSE,
        COLON,
        VAL_SIGN,
        VAL_INT,
        VAL_FRAC,
        WAIT_EOL,
        ERROR
    } state_t;

    localparam logic [7:0] CH_LBRACE = 8'h7B;  // {
    localparam logic [7:0] CH_RBRACE = 8'h7D;  // }
    localparam logic [7:0] CH_QUOTE  = 8'h22;  // "
    localparam logic [7:0] CH_COLON  = 8'h3A;  // :
    localparam logic [7:0] CH_COMMA  = 8'h2C;  // ,
    localparam logic [7:0] CH_DOT    = 8'h2E;  // .
    localparam logic [7:0] CH_MINUS  = 8'h2D;  // -
    localparam logic [7:0] CH_LF     = 8'h0A;  // \n
    localparam logic [7:0] CH_CR     = 8'h0D;  // \r
    localparam logic [7:0] CH_SPACE  = 8'h20;  // space

    // 10^n for small n; fixed loop bound keeps it synthesizable.
    function automatic logic [63:0] POW10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < 19; i++) begin
            if (i < n) r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/json_rx_decoder.sv
// Streaming decoder for newline-terminated JSON feedback frames.
// Emits one (key, fixed-point value) record per pair; malformed frames are
// flushed up to the next newline and reported with frame_error.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | between frames, waiting for '{'
// KEY_OPEN  | expecting opening '"' of a key
// KEY_CHAR  | expecting the single key letter
// KEY_CLOSE | expecting closing '"' of a key
// COLON     | expecting ':'
// VAL_SIGN  | optional '-' then first integer digit
// VAL_INT   | integer digits, '.', or terminator
// VAL_FRAC  | fractional digits or terminator
// WAIT_EOL  | frame closed by '}', waiting for '\n'
// ERROR     | malformed frame, dropping bytes until '\n'
module json_rx_decoder
    import json_rx_pkg::*;
#(
    parameter int VALUE_W        = 32,
    parameter int FRAC_DIGITS    = 3,
    parameter int MAX_INT_DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                in_byte,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [7:0]                field_key,
    output logic signed [VALUE_W-1:0] field_value,
    output logic                      field_last,
    output logic                      field_valid,
    input  logic                      field_ready,
    output logic                      frame_done,
    output logic                      frame_error
);

    localparam int CNT_W = 8;

    state_t state_q, state_d;

    logic [7:0]         key_q;
    logic [VALUE_W-1:0] int_acc, frac_acc;
    logic [CNT_W-1:0]   int_cnt, frac_cnt;
    logic               neg_q, val_end_q;

    logic accept, is_digit, is_alpha, is_space;
    logic [3:0] digit;
    logic digit_int, digit_frac, set_neg, set_end, new_key;
    logic load_field, last_d, pulse_done, pulse_err;
    logic [63:0] mag;
    logic [VALUE_W-1:0] value_d;

    // Single output slot, no bypass: stop taking bytes while a field waits.
    assign in_ready = !field_valid;
    assign accept   = in_valid && in_ready;
    assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign is_alpha = ((in_byte >= 8'h41) && (in_byte <= 8'h5A)) ||
                      ((in_byte >= 8'h61) && (in_byte <= 8'h7A));
    assign is_space = (in_byte == CH_SPACE);
    assign digit    = in_byte[3:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath control decode for the accepted byte.
    always_comb begin
        state_d    = state_q;
        digit_int  = 1'b0;
        digit_frac = 1'b0;
        set_neg    = 1'b0;
        set_end    = 1'b0;
        new_key    = 1'b0;
        load_field = 1'b0;
        last_d     = 1'b0;
        pulse_done = 1'b0;
        pulse_err  = 1'b0;
        if (accept) begin
            if (in_byte == CH_LF && state_q != IDLE && state_q != WAIT_EOL) begin
                pulse_err = 1'b1;
                state_d   = IDLE;
            end else if (in_byte == CH_LBRACE && state_q != IDLE) begin
                state_d = ERROR;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (in_byte == CH_LBRACE) state_d = KEY_OPEN;
                    end
                    KEY_OPEN: begin
                        if (in_byte == CH_QUOTE) state_d = KEY_CHAR;
                        else if (!is_space)      state_d = ERROR;
                    end
                    KEY_CHAR: begin
                        if (is_alpha) begin
                            new_key = 1'b1;
                            state_d = KEY_CLOSE;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                    KEY_CLOSE: begin
                        if (in_byte == CH_QUOTE) state_d = COLON;
                        else                     state_d = ERROR;
                    end
                    COLON: begin
                        if (in_byte == CH_COLON) state_d = VAL_SIGN;
                        else if (!is_space)      state_d = ERROR;
                    end
                    VAL_SIGN: begin
                        if (in_byte == CH_MINUS && !neg_q) begin
                            set_neg = 1'b1;
                        end else if (is_digit) begin
                            digit_int = 1'b1;
                            state_d   = VAL_INT;
                        end else if (!is_space) begin
                            state_d = ERROR;
                        end
                    end
                    VAL_INT, VAL_FRAC: begin
                        // A space ends the number; only a terminator may follow.
                        if (is_digit && !val_end_q) begin
                            if (state_q == VAL_FRAC)                 digit_frac = 1'b1;
                            else if (int_cnt < CNT_W'(MAX_INT_DIGITS)) digit_int = 1'b1;
                            else                                     state_d = ERROR;
                        end else if (in_byte == CH_DOT && !val_end_q && state_q == VAL_INT) begin
                            state_d = VAL_FRAC;
                        end else if (is_space) begin
                            set_end = 1'b1;
                        end else if (in_byte == CH_COMMA) begin
                            load_field = 1'b1;
                            state_d    = KEY_OPEN;
                        end else if (in_byte == CH_RBRACE) begin
                            load_field = 1'b1;
                            last_d     = 1'b1;
                            state_d    = WAIT_EOL;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                    WAIT_EOL: begin
                        if (in_byte == CH_LF) begin
                            pulse_done = 1'b1;
                            state_d    = IDLE;
                        end else if (in_byte != CH_CR && !is_space) begin
                            state_d = ERROR;
                        end
                    end
                    ERROR: state_d = ERROR;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Scale the accumulators; a short fraction is padded out to FRAC_DIGITS.
    always_comb begin
        mag = 64'(int_acc) * POW10(FRAC_DIGITS) +
              64'(frac_acc) * POW10(FRAC_DIGITS - int'(frac_cnt));
        value_d = neg_q ? VALUE_W'(-mag) : VALUE_W'(mag);
    end

    // Key, sign and digit accumulators; cleared when a new key is latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q     <= '0;
            int_acc   <= '0;
            frac_acc  <= '0;
            int_cnt   <= '0;
            frac_cnt  <= '0;
            neg_q     <= 1'b0;
            val_end_q <= 1'b0;
        end else begin
            if (new_key) begin
                key_q     <= in_byte;
                int_acc   <= '0;
                frac_acc  <= '0;
                int_cnt   <= '0;
                frac_cnt  <= '0;
                neg_q     <= 1'b0;
                val_end_q <= 1'b0;
            end
            if (set_neg) neg_q <= 1'b1;
            if (set_end) val_end_q <= 1'b1;
            if (digit_int) begin
                int_acc <= int_acc * VALUE_W'(10) + VALUE_W'(digit);
                int_cnt <= int_cnt + 1'b1;
            end
            // Digits beyond FRAC_DIGITS are truncated.
            if (digit_frac && frac_cnt < CNT_W'(FRAC_DIGITS)) begin
                frac_acc <= frac_acc * VALUE_W'(10) + VALUE_W'(digit);
                frac_cnt <= frac_cnt + 1'b1;
            end
        end
    end

    // Output slot and frame status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_valid <= 1'b0;
            field_key   <= '0;
            field_value <= '0;
            field_last  <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done  <= pulse_done;
            frame_error <= pulse_err;
            if (load_field) begin
                field_valid <= 1'b1;
                field_key   <= key_q;
                field_value <= value_d;
                field_last  <= last_d;
            end else if (field_valid && field_ready) begin
                field_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_json_rx_decoder.sv
// Directed bench for json_rx_decoder: known frames with hand-computed fields.
module tb_json_rx_decoder;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        field_key;
    logic signed [31:0] field_value;
    logic              field_last;
    logic              field_valid;
    logic              field_ready;
    logic              frame_done;
    logic              frame_error;

    json_rx_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .field_key   (field_key),
        .field_value (field_value),
        .field_last  (field_last),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        longint     value;
        logic       last;
    } fld_t;

    fld_t got_q[$];
    fld_t exp_q[$];
    int   n_done;
    int   n_err;
    int   errors = 0;
    int   checks = 0;

    int                 bp_n;
    int                 bp_bad;
    logic [7:0]         bp_key;
    logic signed [31:0] bp_val;
    logic               bp_last;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Record handshaken fields and status pulses away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (field_valid && field_ready) begin
                fld_t f;
                f.key   = field_key;
                f.value = longint'(field_value);
                f.last  = field_last;
                got_q.push_back(f);
            end
            if (frame_done)  n_done++;
            if (frame_error) n_err++;
        end
    end

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic exp_f(input logic [7:0] k, input longint v, input logic l);
        fld_t f;
        f.key   = k;
        f.value = v;
        f.last  = l;
        exp_q.push_back(f);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run_frame(input string s);
        send_str(s);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input int exp_done, input int exp_err);
        int n;
        chk($sformatf("%s.nfields", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.f%0d.key", tag, i),   got_q[i].key,   exp_q[i].key);
            chk($sformatf("%s.f%0d.value", tag, i), got_q[i].value, exp_q[i].value);
            chk($sformatf("%s.f%0d.last", tag, i),  got_q[i].last,  exp_q[i].last);
        end
        chk($sformatf("%s.frame_done", tag),  n_done, exp_done);
        chk($sformatf("%s.frame_error", tag), n_err,  exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_byte     = 8'h00;
        field_ready = 1'b1;
        n_done      = 0;
        n_err       = 0;
        repeat (3) @(negedge clk);
        chk("rst.field_valid", field_valid, 0);
        chk("rst.field_key",   field_key,   0);
        chk("rst.field_value", field_value, 0);
        chk("rst.field_last",  field_last,  0);
        chk("rst.frame_done",  frame_done,  0);
        chk("rst.frame_error", frame_error, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        clear_sb();
        exp_f("T", 1000, 0);
        exp_f("L", 500, 0);
        exp_f("R", 0, 1);
        run_frame("{\"T\":1,\"L\":0.5,\"R\":0.0}\n");
        compare("basic", 1, 0);

        clear_sb();
        exp_f("L", -1250, 0);
        exp_f("R", 12345, 1);
        run_frame("{ \"L\" : -1.25 , \"R\":12.34567 }\r\n");
        compare("spaces", 1, 0);

        clear_sb();
        run_frame("{\"L\":0.5x}\n");
        compare("badchar", 0, 1);

        clear_sb();
        exp_f("R", 2000, 1);
        run_frame("{\"R\":2}\n");
        compare("recover", 1, 0);

        clear_sb();
        run_frame("{\"T\":1234567}\n");
        compare("intdigits7", 0, 1);

        clear_sb();
        exp_f("T", 123456000, 1);
        run_frame("{\"T\":123456.}\n");
        compare("intdigits6_dot", 1, 0);

        clear_sb();
        run_frame("{\"T\":-}\n");
        compare("sign_only", 0, 1);

        clear_sb();
        run_frame("{\"T\":--1}\n");
        compare("double_minus", 0, 1);

        // Stall the consumer on the first field for 20 cycles.
        clear_sb();
        exp_f("T", 1000, 0);
        exp_f("L", -2000, 1);
        field_ready = 1'b0;
        fork
            run_frame("{\"T\":1,\"L\":-2}\n");
            begin
                bp_n   = 0;
                bp_bad = 0;
                @(negedge clk);
                while (!field_valid && bp_n < 200) begin
                    bp_n++;
                    @(negedge clk);
                end
                chk("bp.valid_seen", field_valid, 1);
                bp_key  = field_key;
                bp_val  = field_value;
                bp_last = field_last;
                repeat (20) begin
                    @(negedge clk);
                    if (in_ready || !field_valid || field_key != bp_key ||
                        field_value != bp_val || field_last != bp_last)
                        bp_bad++;
                end
                chk("bp.stall_violations", bp_bad, 0);
                @(posedge clk);
                #1 field_ready = 1'b1;
            end
        join
        compare("backpressure", 1, 0);

        // Reset in the middle of a value.
        clear_sb();
        send_str("{\"T\":12");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst.field_valid", field_valid, 0);
        @(posedge clk);
        #1;
        clear_sb();
        exp_f("L", 3000, 1);
        run_frame("{\"L\":3}\n");
        compare("midrst", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/json_rx_decoder.md
# json_rx_decoder

Streaming decoder for newline-terminated JSON feedback frames arriving from the rover over UART, e.g. `{"T":1001,"L":0.5,"R":-0.25}\n`. It sits between `uart_rx` (byte stream, valid/ready) and the navigation FSM. It emits one record per key/value pair: a single-character key and a signed fixed-point value in milli-units. It flags malformed frames without ever stalling on garbage.

## Interface
- `VALUE_W`, default 32: width of signed output value.
- `FRAC_DIGITS`, default 3: fractional decimal digits kept (scale factor 10^FRAC_DIGITS).
- `MAX_INT_DIGITS`, default 6: maximum integer-part digits accepted.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `in_byte`  in  8  received byte from `uart_rx`.
- `in_valid`  in  1  byte valid.
- `in_ready`  out  1  decoder can accept a byte.
- `field_key`  out  8  ASCII key character.
- `field_value`  out  VALUE_W  signed value × 10^FRAC_DIGITS.
- `field_last`  out  1  field was closed by `}`.
- `field_valid`  out  1  field record valid.
- `field_ready`  in  1  consumer accepts field.
- `frame_done`  out  1  one-cycle pulse: well-formed frame ended by `\n`.
- `frame_error`  out  1  one-cycle pulse: malformed frame ended by `\n`.

## Operation
- Byte handshake: a byte is consumed when `in_valid && in_ready`. `in_ready = !field_valid`; there is a single output slot and no bypass.
- States: IDLE, KEY_OPEN, KEY_CHAR, KEY_CLOSE, COLON, VAL_SIGN, VAL_INT, VAL_FRAC, WAIT_EOL, ERROR.
- IDLE: `{` goes to KEY_OPEN. `\n`, `\r` and space are ignored. Any other byte is discarded and the state stays IDLE.
- KEY_OPEN: `"` goes to KEY_CHAR.
- KEY_CHAR: byte in A–Z or a–z is latched as the key, then KEY_CLOSE.
- KEY_CLOSE: `"` goes to COLON.
- COLON: `:` goes to VAL_SIGN.
- VAL_SIGN: `-` sets the negative flag and stays in VAL_SIGN (second `-` is an error). A digit starts the integer part and goes to VAL_INT.
- VAL_INT: each digit updates `int_acc = int_acc*10 + d`. `.` goes to VAL_FRAC. A digit count above MAX_INT_DIGITS is an error.
- VAL_FRAC: the first FRAC_DIGITS digits update `frac_acc*10 + d`. Further digits are accepted and truncated (no rounding). `.` with zero following digits is legal (`1.` = 1000).
- Terminators in VAL_INT or VAL_FRAC:
  - `,` loads the output slot (`field_last=0`) and goes to KEY_OPEN.
  - `}` loads the slot (`field_last=1`) and goes to WAIT_EOL.
  - A `,` or `}` in VAL_SIGN (no digits yet) is an error.
- Value computation: `value = int_acc*10^FRAC_DIGITS + frac_acc*10^(FRAC_DIGITS - nfrac)`, negated if the sign flag is set. Accumulators reset at each new key.
- Whitespace (space) is skipped in KEY_OPEN, COLON, VAL_SIGN, WAIT_EOL, and after a value before its terminator.
- WAIT_EOL: `\n` pulses `frame_done` and goes to IDLE. `\r` and space are ignored; anything else goes to ERROR.
- Any unexpected byte in any state other than IDLE/ERROR goes to ERROR. A `{` in any non-IDLE state is also an error.
- A `\n` in any non-IDLE, non-WAIT_EOL state (including ERROR) pulses `frame_error` and goes to IDLE.
- ERROR: discards all bytes until `\n`.
- Fields already emitted before an error are not retracted. Consumers qualify on `frame_done`/`frame_error`.

## Timing
- Reset values:
  - `field_valid=0`, `field_key=0`, `field_value=0`, `field_last=0`, `frame_done=0`, `frame_error=0`, state=IDLE.
  - `in_ready=1` from the first cycle after reset deasserts.
- Field latency: `field_valid` rises the cycle after the terminator byte handshake.
- `field_*` are held stable while `field_valid && !field_ready`. `field_valid` falls the cycle after the handshake.
- `frame_done`/`frame_error`: registered, high exactly one cycle, the cycle after the `\n` handshake.
- `\n` handshake in the same cycle as a field accept: both take effect, with no loss.
- Reset mid-frame: parser state, accumulators and the pending field are all discarded. The next frame decodes from scratch.

## Structure
- `json_rx_pkg`: state enum, ASCII constants (`{ } " : , . - \n \r` space), and the `POW10` function.
- No sub-module. This is one FSM plus datapath (two accumulators, digit counters, sign flag, output register).
- Upstream `uart_rx` and downstream consumer live in the top level.

## Test plan
- `{"T":1,"L":0.5,"R":0.0}\n` produces three fields, then `frame_done`:
  - (`T`, 1000, last 0)
  - (`L`, 500, last 0)
  - (`R`, 0, last 1)
- `{ "L" : -1.25 , "R":12.34567 }\r\n` produces (`L`, −1250, 0) and (`R`, 12345, 1); no `frame_error`.
- `{"L":0.5x}\n` emits no field and pulses `frame_error` once. A following `{"R":2}\n` gives (`R`, 2000, 1) and `frame_done`.
- `{"T":1234567}\n` (7 integer digits) gives `frame_error`, no field. `{"T":-}\n` also gives `frame_error`.
- Backpressure: hold `field_ready=0` for 20 cycles after the first field.
  - Required: `in_ready=0` throughout, `field_*` stable, no bytes lost.
  - Release `field_ready` and the rest of the frame decodes correctly.
- Assert `rst` mid-value after `{"T":12`. Then send `{"L":3}\n`; only (`L`, 3000, 1) and `frame_done` are produced.
